// File: rtl/jtframe_scan2x_sl.sv
// Line-doubling scan converter: buffers one game line in a ping-pong RAM and
// replays the previous line twice at 2x pixel rate. The doubled line gets its
// own HS pulse, and the second copy can optionally be dimmed to mimic scanlines.
module jtframe_scan2x_sl #(
  parameter int DW   = 12,
  parameter int HLEN = 384,
  parameter int HSW  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          base_cen,
  input  logic          basex2_cen,
  input  logic [DW-1:0] base_pxl,
  input  logic          HS,
  input  logic [1:0]    sl_mode,
  output logic [DW-1:0] x2_pxl,
  output logic          x2_HS,
  output logic          x2_odd,
  output logic          ovf
);

  localparam int CW = DW / 3;
  localparam int AW = $clog2(HLEN);
  // The write address must be able to hold HLEN itself (its saturation value).
  localparam int WW = $clog2(HLEN + 1);

  logic [DW-1:0] mem [2][HLEN];
  logic [DW-1:0] rd_data;
  logic [WW-1:0] wr_addr;
  logic [AW-1:0] rd_addr, rd_addr_q;
  logic          bank, odd, odd_q, hs_prev, ovf_done;
  logic          line_start, we, wr_bank;
  logic [AW-1:0] wr_idx;

  // Per-channel scanline attenuation, applied only to the odd copy.
  function automatic logic [DW-1:0] dim(input logic [DW-1:0] px,
                                        input logic [1:0]    mode);
    logic [DW-1:0] res;
    logic [CW-1:0] v;
    res = px;
    for (int unsigned c = 0; c < 3; c++) begin
      v = px[c*CW +: CW];
      case (mode)
        2'd1:    res[c*CW +: CW] = v - (v >> 2);
        2'd2:    res[c*CW +: CW] = v >> 1;
        2'd3:    res[c*CW +: CW] = v >> 2;
        default: res[c*CW +: CW] = v;
      endcase
    end
    return res;
  endfunction

  // Write-side decode. The pixel arriving with the HS edge belongs to the new
  // line, so it goes to address 0 of the bank that is about to become active.
  always_comb begin
    line_start = base_cen & HS & ~hs_prev;
    we         = base_cen & (line_start | (wr_addr < WW'(HLEN)));
    wr_bank    = line_start ? ~bank : bank;
    wr_idx     = line_start ? '0 : wr_addr[AW-1:0];
  end

  // Line buffer: write into the active bank, synchronous read from the other.
  always_ff @(posedge clk) begin
    if (we) mem[wr_bank][wr_idx] <= base_pxl;
    if (basex2_cen) rd_data <= mem[~bank][rd_addr];
  end

  // Input side: HS edge detection, bank swap, write address and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_prev  <= 1'b0;
      bank     <= 1'b0;
      wr_addr  <= '0;
      ovf_done <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      ovf <= 1'b0;
      if (base_cen) begin
        hs_prev <= HS;
        if (line_start) begin
          bank     <= ~bank;
          wr_addr  <= WW'(1);
          ovf_done <= 1'b0;
        end else if (wr_addr < WW'(HLEN)) begin
          wr_addr <= wr_addr + WW'(1);
        end else if (!ovf_done) begin
          ovf      <= 1'b1;
          ovf_done <= 1'b1;
        end
      end
    end
  end

  // Output read pointer: a line start wins over the end-of-line wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
      odd     <= 1'b0;
    end else if (line_start) begin
      rd_addr <= '0;
      odd     <= 1'b0;
    end else if (basex2_cen) begin
      if (rd_addr == AW'(HLEN - 1)) begin
        rd_addr <= '0;
        odd     <= ~odd;
      end else begin
        rd_addr <= rd_addr + AW'(1);
      end
    end
  end

  // Tag each read word with the address/odd it came from; these follow the
  // RAM read, not the pointer, so a same-clk line start does not affect them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q <= '0;
      odd_q     <= 1'b0;
    end else if (basex2_cen) begin
      rd_addr_q <= rd_addr;
      odd_q     <= odd;
    end
  end

  // Output register: dimmed pixel, doubled HS and odd-copy marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x2_pxl <= '0;
      x2_HS  <= 1'b0;
      x2_odd <= 1'b0;
    end else if (basex2_cen) begin
      x2_pxl <= odd_q ? dim(rd_data, sl_mode) : rd_data;
      x2_HS  <= rd_addr_q < AW'(HSW);
      x2_odd <= odd_q;
    end
  end

endmodule

// File: tb/tb_jtframe_scan2x_sl.sv
// Directed bench for jtframe_scan2x_sl with the default 12-bit, 384-pixel setup.
// basex2_cen is held high and base_cen runs every other clk (exact 2x ratio).
module tb_jtframe_scan2x_sl;

  localparam int HLEN = 384;
  localparam int HSW  = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        base_cen = 1'b0;
  logic        basex2_cen = 1'b0;
  logic [11:0] base_pxl = '0;
  logic        HS = 1'b0;
  logic [1:0]  sl_mode = 2'd0;
  logic [11:0] x2_pxl;
  logic        x2_HS;
  logic        x2_odd;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int ovf_cnt  = 0;
  int ovf_base = 0;

  jtframe_scan2x_sl #(.DW(12), .HLEN(HLEN), .HSW(HSW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .base_cen   (base_cen),
    .basex2_cen (basex2_cen),
    .base_pxl   (base_pxl),
    .HS         (HS),
    .sl_mode    (sl_mode),
    .x2_pxl     (x2_pxl),
    .x2_HS      (x2_HS),
    .x2_odd     (x2_odd),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ovf) ovf_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] pix(input int kind, input int i);
    case (kind)
      0:       return 12'(i);
      1:       return 12'hFFF;
      default: return 12'hA00 + 12'(i);
    endcase
  endfunction

  // One input line: HS high for the first 4 pixels, one pixel per two clks.
  task automatic drive_line(input int kind, input int npix);
    for (int i = 0; i < npix; i++) begin
      @(negedge clk);
      base_cen = 1'b1;
      HS       = (i < 4);
      base_pxl = pix(kind, i);
      @(negedge clk);
      base_cen = 1'b0;
    end
  endtask

  // Wait for the HS edge, then check ncopies replays of the previously written
  // line. modes holds sl_mode for each copy, two bits per copy.
  task automatic check_copies(input string tag, input int kind, input int ncopies,
                              input logic [11:0] modes);
    int n;
    n = 0;
    sl_mode = modes[1:0];
    do begin
      @(posedge clk);
      n++;
    end while (!(base_cen && HS) && n < 4000);
    check({tag, "_sync"}, 32'(n < 4000), 32'd1);
    repeat (2) @(posedge clk);
    for (int k = 0; k < ncopies * HLEN; k++) begin
      int a, c;
      logic [1:0]  m;
      logic [11:0] e;
      a = k % HLEN;
      c = k / HLEN;
      m = modes[2*c +: 2];
      case (kind)
        0: e = 12'(a);
        2: e = 12'hA00 + 12'(a);
        default: begin
          if (c % 2 == 0) e = 12'hFFF;
          else case (m)
            2'd1:    e = 12'hCCC;
            2'd2:    e = 12'h777;
            2'd3:    e = 12'h333;
            default: e = 12'hFFF;
          endcase
        end
      endcase
      @(negedge clk);
      check($sformatf("%s_pxl[%0d]", tag, k), 32'(x2_pxl), 32'(e));
      check($sformatf("%s_hs[%0d]", tag, k), 32'(x2_HS), 32'(a < HSW));
      check($sformatf("%s_odd[%0d]", tag, k), 32'(x2_odd), 32'(c % 2));
      if ((k + 1) % HLEN == 0 && c + 1 < ncopies) sl_mode = modes[2*(c+1) +: 2];
      @(posedge clk);
    end
  endtask

  initial begin
    // Reset held with enables and HS active: outputs must stay at 0.
    basex2_cen = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      base_cen = (i % 2 == 0);
      HS       = (i % 3 == 0);
      base_pxl = 12'($urandom);
    end
    @(negedge clk);
    check("rst_pxl", 32'(x2_pxl), 32'd0);
    check("rst_hs",  32'(x2_HS),  32'd0);
    check("rst_odd", 32'(x2_odd), 32'd0);
    check("rst_ovf", 32'(ovf),    32'd0);
    base_cen = 1'b0;
    HS       = 1'b0;
    rst_n    = 1'b1;
    ovf_base = ovf_cnt;

    // Ramp line, then its two copies while a constant line is written.
    drive_line(0, HLEN);
    fork
      drive_line(1, HLEN);
      check_copies("ramp", 0, 2, 12'b00_00_00_00_00_00);
    join
    check("ovf_exact_len", 32'(ovf_cnt - ovf_base), 32'd0);

    // Constant line replayed 6 times without HS, dim mode changed per pair;
    // the single line written meanwhile is 400 pixels long.
    ovf_base = ovf_cnt;
    fork
      drive_line(2, 400);
      check_copies("dim", 1, 6, 12'b11_11_10_10_01_01);
    join
    check("ovf_once", 32'(ovf_cnt - ovf_base), 32'd1);

    // The overflowed line must hold its first 384 pixels only.
    ovf_base = ovf_cnt;
    fork
      drive_line(0, HLEN);
      check_copies("ovfdata", 2, 2, 12'b00_00_00_00_00_00);
    join
    check("ovf_none", 32'(ovf_cnt - ovf_base), 32'd0);

    // Asynchronous reset at output pixel 100 of the ramp replay.
    fork
      drive_line(1, 8);
      begin
        int n;
        n = 0;
        do begin
          @(posedge clk);
          n++;
        end while (!(base_cen && HS) && n < 4000);
        check("arst_sync", 32'(n < 4000), 32'd1);
        repeat (102) @(posedge clk);
        #1;
        check("arst_pre_pxl", 32'(x2_pxl), 32'd100);
        rst_n = 1'b0;
        #1;
        check("arst_pxl", 32'(x2_pxl), 32'd0);
        check("arst_hs",  32'(x2_HS),  32'd0);
        check("arst_odd", 32'(x2_odd), 32'd0);
        check("arst_ovf", 32'(ovf),    32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end
    join

    // After the next HS edge the untouched ramp bank replays normally.
    fork
      drive_line(1, HLEN);
      check_copies("resume", 0, 2, 12'b00_00_00_00_00_00);
    join

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtframe_scan2x_sl.md
Name: jtframe_scan2x_sl

Overview:
- Parametrised line-doubling scan converter with selectable scanline dimming.
- Sits between the game video output (base pixel rate, `cen6` domain) and the VGA/OSD path of the frame wrapper.
- Writes one game line into a ping-pong line buffer while replaying the previous line twice at double pixel rate.
- Generates the doubled horizontal sync. Optionally darkens every second output line.

Parameters:
- DW, 12: pixel width; three equal colour channels of CW=DW/3 bits each, R in the MSBs; DW must be a multiple of 3.
- HLEN, 384: pixels per input line (buffer depth per bank); address width AW=$clog2(HLEN).
- HSW, 32: width of `x2_HS` pulse in output pixels; must be < HLEN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- base_cen  in  1  input pixel clock enable
- basex2_cen  in  1  output pixel clock enable (2x base_cen rate)
- base_pxl  in  DW  input pixel, sampled on base_cen
- HS  in  1  input horizontal sync, active high
- sl_mode  in  2  scanline mode: 0 off, 1 25% dim, 2 50% dim, 3 75% dim
- x2_pxl  out  DW  doubled-rate pixel
- x2_HS  out  1  doubled-rate horizontal sync, active high
- x2_odd  out  1  high while the second copy of a line is output
- ovf  out  1  one-clk pulse when an input line exceeds HLEN pixels

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset: all outputs 0, wr_addr=0, rd_addr=0, bank=0, odd=0, HS history=0. Reset mid-line: all state clears immediately; first line after reset shows buffer contents (undefined), no X-propagation required beyond memory.
- Line buffer: 2 banks x HLEN x DW, synchronous read, one write port (bank) and one read port (~bank).
- Input side, on base_cen:
  - HS sampled; a rising edge (HS=1, previous sample 0) starts a new line.
  - On that edge: bank toggles, wr_addr=0, rd_addr=0, odd=0. The pixel present at that base_cen is written at address 0 of the new bank.
  - Otherwise base_pxl is written at wr_addr and wr_addr increments.
  - wr_addr saturates at HLEN. Writes at wr_addr==HLEN are dropped and ovf pulses once per line.
- Output side, on basex2_cen:
  - Memory is read at rd_addr.
  - rd_addr increments. At HLEN-1 it wraps to 0 and odd toggles.
  - If no new HS edge arrives, the line repeats indefinitely with alternating odd.
  - A line-start event has priority over the rd_addr wrap on the same clk.
- Output register, updated on basex2_cen:
  - x2_pxl = dim(word read at the previous basex2_cen). Latency is exactly one basex2_cen period from address to pixel.
  - x2_HS = (rd_addr of that word < HSW).
  - x2_odd = odd of that word.
- dim, per channel v (CW bits, truncating shifts), applied only when odd=1 and sl_mode!=0:
  - mode1: v - (v>>2)
  - mode2: v>>1
  - mode3: v>>2
  - Even lines and mode 0 pass through unchanged.
- sl_mode is sampled at every output pixel; a change takes effect on the next basex2_cen.
- Simultaneous base_cen and basex2_cen on the same clk are legal. The read bank is never the write bank, so no read/write collision occurs.
- Short input line (HS edge before HLEN pixels): buffer tail keeps stale data from two lines earlier; reads are not truncated.

Test Plan:
- Reset: hold rst_n=0 with cens toggling -> x2_pxl=0, x2_HS=0, x2_odd=0, ovf=0. Release -> the first HS edge switches bank to 1.
- Ramp, DW=12, HLEN=384, sl_mode=0:
  - Stimulus: write line of pixel n = n[11:0], then HS edge.
  - Required: next 768 output pixels are 0..383 then 0..383.
  - Required: x2_odd=0 for the first copy, 1 for the second.
  - Required: x2_HS high for exactly the first 32 pixels of each copy.
- Dimming: constant input 12'hFFF, odd copy:
  - mode1 -> 12'hCCC
  - mode2 -> 12'h777
  - mode3 -> 12'h333
  - Even copy -> 12'hFFF in all modes.
- Overflow: feed 400 pixels between HS edges -> ovf pulses exactly once. Addresses 0..383 hold the first 384 pixels; pixels 384..399 are discarded.
- Missing HS: stop HS for 3 line times -> same line replays 6 times, x2_odd alternating 0,1,0,1,0,1.
- Mid-line async reset: assert rst_n=0 at output pixel 100 for 3 clk -> outputs go 0 within the same cycle without clk edge. Operation resumes correctly after the next HS edge.
